// File: rtl/alu_writeback_stage_if.sv
// ALU result / register-file writeback bundle between producer, stage and consumer.
interface alu_writeback_stage_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [AW-1:0]    in_rd;
  logic [WIDTH-1:0] in_result;
  logic             in_is_slt;
  logic             wb_stall;
  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             fwd_valid;
  logic [AW-1:0]    fwd_rd;
  logic [WIDTH-1:0] fwd_data;
  logic [1:0]       count;

  // Producer / register-file / forwarding-consumer side
  modport master (
    output in_valid, in_rd, in_result, in_is_slt, wb_stall,
    input  in_ready, wb_en, wb_addr, wb_data, fwd_valid, fwd_rd, fwd_data, count
  );

  // Writeback stage side
  modport slave (
    input  in_valid, in_rd, in_result, in_is_slt, wb_stall,
    output in_ready, wb_en, wb_addr, wb_data, fwd_valid, fwd_rd, fwd_data, count
  );
endinterface

// File: rtl/alu_writeback_stage.sv
// ALU writeback stage: 2-entry result buffer, SLT normalisation, r0 write
// suppression, registered register-file write port and youngest-result forwarding.
module alu_writeback_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input logic                 clk,
  input logic                 rst,
  alu_writeback_stage_if.slave bus
);

  logic [AW-1:0]    rd_mem_r   [2];
  logic [WIDTH-1:0] data_mem_r [2];
  logic             head_r;
  logic             tail_r;
  logic [1:0]       count_r;
  logic             wb_en_r;
  logic [AW-1:0]    wb_addr_r;
  logic [WIDTH-1:0] wb_data_r;

  logic             in_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             young_s;
  logic [WIDTH-1:0] norm_data_s;
  logic             fwd_valid_s;
  logic [AW-1:0]    fwd_rd_s;
  logic [WIDTH-1:0] fwd_data_s;

  // SLT results carry only bit 0; everything above it is forced to zero.
  function automatic logic [WIDTH-1:0] normalise(input logic [WIDTH-1:0] result,
                                                 input logic             is_slt);
    logic [WIDTH-1:0] value;
    if (is_slt) begin
      value = {{(WIDTH-1){1'b0}}, result[0]};
    end else begin
      value = result;
    end
    return value;
  endfunction

  // Handshake decode: accept while not full and out of reset, drain unless stalled.
  always_comb begin
    in_ready_s  = (!rst) && (count_r != 2'd2);
    push_s      = bus.in_valid && in_ready_s;
    pop_s       = (count_r != 2'd0) && !bus.wb_stall;
    young_s     = ~tail_r;
    norm_data_s = normalise(bus.in_result, bus.in_is_slt);
  end

  // Buffer storage, wrap-around pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r        <= 1'b0;
      tail_r        <= 1'b0;
      count_r       <= 2'd0;
      rd_mem_r[0]   <= {AW{1'b0}};
      rd_mem_r[1]   <= {AW{1'b0}};
      data_mem_r[0] <= {WIDTH{1'b0}};
      data_mem_r[1] <= {WIDTH{1'b0}};
    end else begin
      if (push_s) begin
        rd_mem_r[tail_r]   <= bus.in_rd;
        data_mem_r[tail_r] <= norm_data_s;
        tail_r             <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Register-file write port; popped r0 entries are dropped without a strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_en_r   <= 1'b0;
      wb_addr_r <= {AW{1'b0}};
      wb_data_r <= {WIDTH{1'b0}};
    end else if (pop_s) begin
      if (rd_mem_r[head_r] != {AW{1'b0}}) begin
        wb_en_r   <= 1'b1;
        wb_addr_r <= rd_mem_r[head_r];
        wb_data_r <= data_mem_r[head_r];
      end else begin
        wb_en_r <= 1'b0;
      end
    end else begin
      wb_en_r <= 1'b0;
    end
  end

  // Forwarding: youngest buffered entry first, then the write in flight; r0 never reported.
  always_comb begin
    fwd_valid_s = 1'b0;
    fwd_rd_s    = rd_mem_r[young_s];
    fwd_data_s  = data_mem_r[young_s];
    if (count_r != 2'd0) begin
      fwd_valid_s = (rd_mem_r[young_s] != {AW{1'b0}});
    end else if (wb_en_r) begin
      fwd_valid_s = (wb_addr_r != {AW{1'b0}});
      fwd_rd_s    = wb_addr_r;
      fwd_data_s  = wb_data_r;
    end else begin
      fwd_valid_s = 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.wb_en     = wb_en_r;
  assign bus.wb_addr   = wb_addr_r;
  assign bus.wb_data   = wb_data_r;
  assign bus.fwd_valid = fwd_valid_s;
  assign bus.fwd_rd    = fwd_rd_s;
  assign bus.fwd_data  = fwd_data_s;
  assign bus.count     = count_r;

endmodule
